glb_bank_arbiter: RTL and testbench
===================================

GLB_BANK_ARBITER -- requirements
Module: glb_bank_arbiter

Interface
REQ-001 SHALL have parameter BANK_ADDR_WIDTH, default 16: bank word-byte address width.
REQ-002 SHALL have parameter BANK_DATA_WIDTH, default 64: bank data width.
REQ-003 SHALL have parameter BANK_STRB_WIDTH, default 8: byte-strobe width.
REQ-004 SHALL have parameter RD_LATENCY, default 2: cycles from registered mem request to mem_rdata valid.
REQ-005 SHALL have parameter STARVE_LIMIT, default 4: consecutive denied cycles before a DMA port is forced.
REQ-006 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have ports proc_req/proc_wr  input  1 each  processor request; 1=write, 0=read.
REQ-009 SHALL have ports proc_addr  input  BANK_ADDR_WIDTH; proc_wdata  input  BANK_DATA_WIDTH; proc_wstrb  input  BANK_STRB_WIDTH.
REQ-010 SHALL have ports proc_gnt  output  1  grant; proc_rvalid  output  1  read data for processor on bank_rdata.
REQ-011 SHALL have ports st_req  input  1; st_addr  input  BANK_ADDR_WIDTH; st_wdata  input  BANK_DATA_WIDTH; st_wstrb  input  BANK_STRB_WIDTH; st_gnt  output  1  (store DMA, write-only).
REQ-012 SHALL have ports ld_req  input  1; ld_addr  input  BANK_ADDR_WIDTH; ld_gnt  output  1; ld_rvalid  output  1  (load DMA, read-only).
REQ-013 SHALL have ports mem_ce, mem_we  output  1 each; mem_addr  output  BANK_ADDR_WIDTH; mem_wdata  output  BANK_DATA_WIDTH; mem_wstrb  output  BANK_STRB_WIDTH  (registered SRAM request).
REQ-014 SHALL have ports mem_rdata  input  BANK_DATA_WIDTH; bank_rdata  output  BANK_DATA_WIDTH  (combinational pass-through of mem_rdata).

Function
REQ-015 Transfer SHALL occur in cycle N iff req and gnt both high in N; gnt combinational from req and state; at most one gnt high per cycle.
REQ-016 Requests SHALL be held stable until granted; a dropped req clears that port's pending state without transfer.
REQ-017 Priority SHALL be: (a) starved DMA port (starve_cnt >= STARVE_LIMIT and req); (b) proc_req; (c) DMA ports by round-robin pointer rr (0 favours st, 1 favours ld).
REQ-018 If both DMA ports starved, rr SHALL pick; rr SHALL toggle to the other DMA port after every DMA grant, unchanged otherwise.
REQ-019 Each DMA starve_cnt (width clog2(STARVE_LIMIT+1)) SHALL increment, saturating at STARVE_LIMIT, on req & !gnt; clear on gnt or !req.
REQ-020 Granted request SHALL appear on mem_* in cycle N+1: mem_ce=1, mem_we=1 for st and proc writes, 0 for reads; addr/wdata/wstrb copied; mem_ce=0 and mem_we=0 when no grant; wstrb=0 writes issued unmodified.
REQ-021 Each read grant SHALL push a port tag into a (1+RD_LATENCY)-stage pipeline; proc_rvalid or ld_rvalid SHALL be high exactly in cycle N+1+RD_LATENCY, one cycle per read.
REQ-022 Back-to-back reads to alternating ports SHALL return in grant order with no bubbles; throughput one access per cycle.
REQ-023 Writes SHALL never assert any rvalid.

Reset
REQ-024 On reset: mem_ce=0, mem_we=0, mem_addr/wdata/wstrb=0, tag pipeline cleared, proc_rvalid=ld_rvalid=0, starve counters=0, rr=0.
REQ-025 Reset mid-operation SHALL drop in-flight reads (no rvalid afterwards); gnt outputs SHALL be 0 while reset is high.

Verification
REQ-026 proc read addr 0x0010 alone at cycle 5 -> proc_gnt cycle 5, mem_ce=1,mem_we=0,mem_addr=0x0010 cycle 6, proc_rvalid cycle 8 only.
REQ-027 st_req and ld_req together from reset, no proc -> st granted first, ld next cycle, alternating thereafter.
REQ-028 proc_req continuous plus st_req continuous -> st denied 4 cycles, granted on cycle 5, starve_cnt back to 0, proc resumes.
REQ-029 proc read, ld read, proc read in cycles 10-12 -> rvalid proc/ld/proc in cycles 13/14/15, bank_rdata equals mem_rdata each cycle.
REQ-030 ld read granted cycle 20, reset high cycle 21 -> ld_rvalid never asserts; all outputs at reset values cycle 22.
REQ-031 st write wstrb=0x0F wdata=0xDEADBEEF_CAFEF00D -> mem_we=1, mem_wstrb=0x0F, exact wdata next cycle, no rvalid.

Source files
------------

// File: rtl/glb_bank_arbiter.sv
// Single-bank SRAM arbiter shared by a processor port and two DMA ports
// (store DMA: write-only, load DMA: read-only). Grants are combinational;
// the winning request is registered onto mem_* one cycle later, and read
// returns are tracked by a shift register of port tags whose length matches
// the SRAM read latency. DMA ports are protected from starvation by
// per-port saturating denial counters.
module glb_bank_arbiter #(
    parameter int BANK_ADDR_WIDTH = 16,
    parameter int BANK_DATA_WIDTH = 64,
    parameter int BANK_STRB_WIDTH = 8,
    parameter int RD_LATENCY      = 2,
    parameter int STARVE_LIMIT    = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       proc_req,
    input  logic                       proc_wr,
    input  logic [BANK_ADDR_WIDTH-1:0] proc_addr,
    input  logic [BANK_DATA_WIDTH-1:0] proc_wdata,
    input  logic [BANK_STRB_WIDTH-1:0] proc_wstrb,
    output logic                       proc_gnt,
    output logic                       proc_rvalid,
    input  logic                       st_req,
    input  logic [BANK_ADDR_WIDTH-1:0] st_addr,
    input  logic [BANK_DATA_WIDTH-1:0] st_wdata,
    input  logic [BANK_STRB_WIDTH-1:0] st_wstrb,
    output logic                       st_gnt,
    input  logic                       ld_req,
    input  logic [BANK_ADDR_WIDTH-1:0] ld_addr,
    output logic                       ld_gnt,
    output logic                       ld_rvalid,
    output logic                       mem_ce,
    output logic                       mem_we,
    output logic [BANK_ADDR_WIDTH-1:0] mem_addr,
    output logic [BANK_DATA_WIDTH-1:0] mem_wdata,
    output logic [BANK_STRB_WIDTH-1:0] mem_wstrb,
    input  logic [BANK_DATA_WIDTH-1:0] mem_rdata,
    output logic [BANK_DATA_WIDTH-1:0] bank_rdata
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    // Starvation counters and DMA round-robin pointer (0 favours st, 1 favours ld)
    logic [CNT_W-1:0] st_cnt_q, st_cnt_d;
    logic [CNT_W-1:0] ld_cnt_q, ld_cnt_d;
    logic             rr_q, rr_d;
    logic             st_starved_s, ld_starved_s;

    // Registered SRAM request
    logic                       mem_ce_q, mem_ce_d;
    logic                       mem_we_q, mem_we_d;
    logic [BANK_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [BANK_DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [BANK_STRB_WIDTH-1:0] mem_wstrb_q, mem_wstrb_d;

    // Read-return tag pipeline: bit 1 = processor read, bit 0 = load DMA read
    logic [RD_LATENCY:0][1:0] tag_q, tag_d;

    // Grant selection: starved DMA first, then processor, then round-robin DMA
    always_comb begin
        proc_gnt     = 1'b0;
        st_gnt       = 1'b0;
        ld_gnt       = 1'b0;
        st_starved_s = st_req && (st_cnt_q >= LIMIT);
        ld_starved_s = ld_req && (ld_cnt_q >= LIMIT);
        if (reset) begin
            proc_gnt = 1'b0;
        end else if (st_starved_s && ld_starved_s) begin
            st_gnt = ~rr_q;
            ld_gnt = rr_q;
        end else if (st_starved_s) begin
            st_gnt = 1'b1;
        end else if (ld_starved_s) begin
            ld_gnt = 1'b1;
        end else if (proc_req) begin
            proc_gnt = 1'b1;
        end else if (st_req && ld_req) begin
            st_gnt = ~rr_q;
            ld_gnt = rr_q;
        end else if (st_req) begin
            st_gnt = 1'b1;
        end else if (ld_req) begin
            ld_gnt = 1'b1;
        end else begin
            proc_gnt = 1'b0;
        end
    end

    // Next state for round-robin pointer and starvation counters
    always_comb begin
        rr_d     = rr_q;
        st_cnt_d = st_cnt_q;
        ld_cnt_d = ld_cnt_q;
        if (st_gnt || ld_gnt) begin
            rr_d = ~rr_q;
        end else begin
            rr_d = rr_q;
        end
        if (st_gnt || !st_req) begin
            st_cnt_d = {CNT_W{1'b0}};
        end else if (st_cnt_q < LIMIT) begin
            st_cnt_d = st_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            st_cnt_d = st_cnt_q;
        end
        if (ld_gnt || !ld_req) begin
            ld_cnt_d = {CNT_W{1'b0}};
        end else if (ld_cnt_q < LIMIT) begin
            ld_cnt_d = ld_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            ld_cnt_d = ld_cnt_q;
        end
    end

    // Build the next SRAM request from the winning port; idle keeps address/data
    always_comb begin
        mem_ce_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        if (proc_gnt) begin
            mem_ce_d    = 1'b1;
            mem_we_d    = proc_wr;
            mem_addr_d  = proc_addr;
            mem_wdata_d = proc_wdata;
            mem_wstrb_d = proc_wstrb;
        end else if (st_gnt) begin
            mem_ce_d    = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = st_addr;
            mem_wdata_d = st_wdata;
            mem_wstrb_d = st_wstrb;
        end else if (ld_gnt) begin
            mem_ce_d    = 1'b1;
            mem_we_d    = 1'b0;
            mem_addr_d  = ld_addr;
            mem_wdata_d = {BANK_DATA_WIDTH{1'b0}};
            mem_wstrb_d = {BANK_STRB_WIDTH{1'b0}};
        end else begin
            mem_ce_d    = 1'b0;
            mem_we_d    = 1'b0;
        end
    end

    // Shift read tags toward the return point; only read grants enter
    always_comb begin
        tag_d    = tag_q;
        tag_d[0] = {proc_gnt & ~proc_wr, ld_gnt};
        for (int k = 1; k <= RD_LATENCY; k++) begin
            tag_d[k] = tag_q[k-1];
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_q        <= 1'b0;
            st_cnt_q    <= {CNT_W{1'b0}};
            ld_cnt_q    <= {CNT_W{1'b0}};
            mem_ce_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {BANK_ADDR_WIDTH{1'b0}};
            mem_wdata_q <= {BANK_DATA_WIDTH{1'b0}};
            mem_wstrb_q <= {BANK_STRB_WIDTH{1'b0}};
            tag_q       <= {((RD_LATENCY + 1) * 2){1'b0}};
        end else begin
            rr_q        <= rr_d;
            st_cnt_q    <= st_cnt_d;
            ld_cnt_q    <= ld_cnt_d;
            mem_ce_q    <= mem_ce_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            tag_q       <= tag_d;
        end
    end

    assign mem_ce      = mem_ce_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_wstrb   = mem_wstrb_q;
    assign proc_rvalid = tag_q[RD_LATENCY][1];
    assign ld_rvalid   = tag_q[RD_LATENCY][0];
    assign bank_rdata  = mem_rdata;

endmodule

// File: tb/tb_glb_bank_arbiter.sv
// Directed self-checking bench for glb_bank_arbiter (default parameters).
// Inputs change 1 time unit after the rising edge; checks are made 1 unit
// later, so registered outputs reflect the previous cycle's grant and
// grants reflect the inputs just driven.
module tb_glb_bank_arbiter;

    logic        clk;
    logic        reset;
    logic        proc_req, proc_wr, proc_gnt, proc_rvalid;
    logic [15:0] proc_addr;
    logic [63:0] proc_wdata;
    logic [7:0]  proc_wstrb;
    logic        st_req, st_gnt;
    logic [15:0] st_addr;
    logic [63:0] st_wdata;
    logic [7:0]  st_wstrb;
    logic        ld_req, ld_gnt, ld_rvalid;
    logic [15:0] ld_addr;
    logic        mem_ce, mem_we;
    logic [15:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wstrb;
    logic [63:0] mem_rdata, bank_rdata;

    int tests_run = 0;
    int tests_failed = 0;

    glb_bank_arbiter dut (
        .clk(clk), .reset(reset),
        .proc_req(proc_req), .proc_wr(proc_wr), .proc_addr(proc_addr),
        .proc_wdata(proc_wdata), .proc_wstrb(proc_wstrb),
        .proc_gnt(proc_gnt), .proc_rvalid(proc_rvalid),
        .st_req(st_req), .st_addr(st_addr), .st_wdata(st_wdata),
        .st_wstrb(st_wstrb), .st_gnt(st_gnt),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid),
        .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata), .bank_rdata(bank_rdata)
    );

    // 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        proc_req = 1'b0;
        st_req   = 1'b0;
        ld_req   = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        proc_req = 1'b1; proc_wr = 1'b0; proc_addr = 16'h0000;
        proc_wdata = 64'h0; proc_wstrb = 8'h00;
        st_req = 1'b1; st_addr = 16'h0000; st_wdata = 64'h0; st_wstrb = 8'h00;
        ld_req = 1'b1; ld_addr = 16'h0000;
        mem_rdata = 64'h0;

        // Reset: no grants even with every port requesting, outputs cleared
        cyc(); #1;
        chk("rst_proc_gnt", proc_gnt, 1'b0);
        chk("rst_st_gnt", st_gnt, 1'b0);
        chk("rst_ld_gnt", ld_gnt, 1'b0);
        cyc(); #1;
        chk("rst_mem_ce", mem_ce, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, 16'h0000);
        chk("rst_proc_rvalid", proc_rvalid, 1'b0);
        chk("rst_ld_rvalid", ld_rvalid, 1'b0);
        idle_inputs();
        cyc();
        reset = 1'b0;
        #1;

        // Single processor read of 0x0010
        cyc();
        proc_req = 1'b1; proc_wr = 1'b0; proc_addr = 16'h0010;
        #1;
        chk("A_proc_gnt", proc_gnt, 1'b1);
        chk("A_st_gnt", st_gnt, 1'b0);
        chk("A_ld_gnt", ld_gnt, 1'b0);
        cyc();
        proc_req = 1'b0;
        #1;
        chk("A_mem_ce", mem_ce, 1'b1);
        chk("A_mem_we", mem_we, 1'b0);
        chk("A_mem_addr", mem_addr, 16'h0010);
        chk("A_rvalid_n1", proc_rvalid, 1'b0);
        cyc(); #1;
        chk("A_mem_ce_idle", mem_ce, 1'b0);
        chk("A_rvalid_n2", proc_rvalid, 1'b0);
        cyc(); #1;
        chk("A_rvalid_n3", proc_rvalid, 1'b1);
        chk("A_ld_rvalid_n3", ld_rvalid, 1'b0);
        cyc(); #1;
        chk("A_rvalid_n4", proc_rvalid, 1'b0);

        // Both DMA ports from reset: st first, then alternate
        do_reset();
        st_req = 1'b1; st_addr = 16'h0100; st_wdata = 64'h1111; st_wstrb = 8'hFF;
        ld_req = 1'b1; ld_addr = 16'h0200;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) cyc();
            #1;
            chk("B_st_gnt", st_gnt, (i % 2) == 0);
            chk("B_ld_gnt", ld_gnt, (i % 2) == 1);
            if (i > 0) chk("B_mem_we", mem_we, ((i - 1) % 2) == 0);
        end
        cyc();
        idle_inputs();
        #1;
        chk("B_mem_we_ld", mem_we, 1'b0);
        chk("B_mem_addr_ld", mem_addr, 16'h0200);
        chk("B_ld_rvalid_c4", ld_rvalid, 1'b1);
        cyc(); #1;
        chk("B_ld_rvalid_c5", ld_rvalid, 1'b0);
        cyc(); #1;
        chk("B_ld_rvalid_c6", ld_rvalid, 1'b1);
        cyc(); #1;
        chk("B_ld_rvalid_c7", ld_rvalid, 1'b0);

        // Processor hogging vs store DMA: st forced after 4 denials
        do_reset();
        proc_req = 1'b1; proc_wr = 1'b1; proc_addr = 16'h0300;
        proc_wdata = 64'h1; proc_wstrb = 8'hFF;
        st_req = 1'b1; st_addr = 16'h0400; st_wdata = 64'h2; st_wstrb = 8'hF0;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) cyc();
            #1;
            chk("C_st_gnt", st_gnt, i == 4);
            chk("C_proc_gnt", proc_gnt, i != 4);
            if (i == 5) begin
                chk("C_mem_addr_st", mem_addr, 16'h0400);
                chk("C_mem_we_st", mem_we, 1'b1);
                chk("C_mem_wstrb_st", mem_wstrb, 8'hF0);
            end
            if (i >= 3) chk("C_no_rvalid", proc_rvalid, 1'b0);
        end
        idle_inputs();

        // proc / ld / proc reads back to back, returns in order with no bubbles
        do_reset();
        proc_req = 1'b1; proc_wr = 1'b0; proc_addr = 16'h0010;
        #1;
        chk("D_proc_gnt0", proc_gnt, 1'b1);
        cyc();
        proc_req = 1'b0; ld_req = 1'b1; ld_addr = 16'h0020;
        #1;
        chk("D_ld_gnt1", ld_gnt, 1'b1);
        chk("D_mem_addr1", mem_addr, 16'h0010);
        cyc();
        ld_req = 1'b0; proc_req = 1'b1; proc_addr = 16'h0030;
        #1;
        chk("D_proc_gnt2", proc_gnt, 1'b1);
        chk("D_mem_addr2", mem_addr, 16'h0020);
        chk("D_mem_we2", mem_we, 1'b0);
        for (int k = 3; k <= 6; k++) begin
            logic [63:0] d;
            cyc();
            proc_req = 1'b0;
            d = 64'hC0DE_0000_0000_0000 + 64'(k);
            mem_rdata = d;
            #1;
            chk("D_proc_rvalid", proc_rvalid, (k == 3) || (k == 5));
            chk("D_ld_rvalid", ld_rvalid, k == 4);
            chk("D_bank_rdata", bank_rdata, d);
        end

        // Reset during an in-flight load read drops the return
        do_reset();
        ld_req = 1'b1; ld_addr = 16'h0050;
        #1;
        chk("E_ld_gnt", ld_gnt, 1'b1);
        cyc();
        ld_req = 1'b0; reset = 1'b1; proc_req = 1'b1; proc_wr = 1'b0; st_req = 1'b1;
        #1;
        chk("E_proc_gnt_rst", proc_gnt, 1'b0);
        chk("E_st_gnt_rst", st_gnt, 1'b0);
        chk("E_ld_gnt_rst", ld_gnt, 1'b0);
        cyc();
        reset = 1'b0;
        idle_inputs();
        #1;
        chk("E_mem_ce", mem_ce, 1'b0);
        chk("E_mem_we", mem_we, 1'b0);
        chk("E_mem_addr", mem_addr, 16'h0000);
        chk("E_mem_wdata", mem_wdata, 64'h0);
        chk("E_mem_wstrb", mem_wstrb, 8'h00);
        chk("E_ld_rvalid_c2", ld_rvalid, 1'b0);
        cyc(); #1;
        chk("E_ld_rvalid_c3", ld_rvalid, 1'b0);
        cyc(); #1;
        chk("E_ld_rvalid_c4", ld_rvalid, 1'b0);

        // Partial-strobe store write, then a zero-strobe processor write
        do_reset();
        st_req = 1'b1; st_addr = 16'h0060;
        st_wdata = 64'hDEADBEEF_CAFEF00D; st_wstrb = 8'h0F;
        #1;
        chk("F_st_gnt", st_gnt, 1'b1);
        cyc();
        st_req = 1'b0;
        proc_req = 1'b1; proc_wr = 1'b1; proc_addr = 16'h0070;
        proc_wdata = 64'h55; proc_wstrb = 8'h00;
        #1;
        chk("F_mem_ce", mem_ce, 1'b1);
        chk("F_mem_we", mem_we, 1'b1);
        chk("F_mem_wstrb", mem_wstrb, 8'h0F);
        chk("F_mem_wdata", mem_wdata, 64'hDEADBEEF_CAFEF00D);
        chk("F_mem_addr", mem_addr, 16'h0060);
        chk("F_proc_gnt", proc_gnt, 1'b1);
        cyc();
        proc_req = 1'b0;
        #1;
        chk("F_pw_mem_we", mem_we, 1'b1);
        chk("F_pw_mem_wstrb", mem_wstrb, 8'h00);
        chk("F_pw_mem_addr", mem_addr, 16'h0070);
        for (int k = 0; k < 3; k++) begin
            cyc(); #1;
            chk("F_no_proc_rvalid", proc_rvalid, 1'b0);
            chk("F_no_ld_rvalid", ld_rvalid, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
